// File: rtl/mac_acc_pipe.sv
// Pipelined unsigned multiply-accumulate: a multiply stage feeding an accumulate stage,
// emitting one dot-product result per vector on a held valid/ready output.
module mac_acc_pipe #(
    parameter int A_W      = 4,
    parameter int B_W      = 4,
    parameter int ACC_W    = 12,
    parameter int CNT_W    = 8,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   in_a,
    input  logic [B_W-1:0]   in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_cnt
);

    localparam int P_W = A_W + B_W;

    // Stage 1: registered product
    logic             r_s1_valid;
    logic             r_s1_last;
    logic [P_W-1:0]   r_s1_prod;

    // Stage 2: running accumulation state for the current vector
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;

    // Output holding register
    logic             r_out_valid;
    logic [ACC_W-1:0] r_out_acc;
    logic             r_out_ovf;
    logic [CNT_W-1:0] r_out_cnt;

    logic             w_en;
    logic             w_accept;
    logic [P_W-1:0]   w_prod;
    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_ovf_next;
    logic [CNT_W-1:0] w_cnt_next;

    // The whole pipeline advances only when the output slot is free or being drained.
    assign w_en     = !r_out_valid || out_ready;
    assign w_accept = in_valid && w_en;
    assign w_prod   = P_W'(in_a) * P_W'(in_b);

    assign w_sum   = {1'b0, r_acc} + {1'b0, ACC_W'(r_s1_prod)};
    assign w_carry = w_sum[ACC_W];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_acc_next = w_sum[ACC_W-1:0];
        w_ovf_next = r_ovf | w_carry;
        w_cnt_next = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
        if ((SATURATE != 0) && w_carry) begin
            w_acc_next = {ACC_W{1'b1}};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_prod   <= '0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_acc   <= '0;
            r_out_ovf   <= 1'b0;
            r_out_cnt   <= '0;
        end else if (w_en) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_prod <= w_prod;
                r_s1_last <= in_last;
            end

            if (r_s1_valid) begin
                if (r_s1_last) begin
                    // Publish the finished vector and restart from zero in the same edge.
                    r_out_acc <= w_acc_next;
                    r_out_ovf <= w_ovf_next;
                    r_out_cnt <= w_cnt_next;
                    r_acc     <= '0;
                    r_ovf     <= 1'b0;
                    r_cnt     <= '0;
                end else begin
                    r_acc <= w_acc_next;
                    r_ovf <= w_ovf_next;
                    r_cnt <= w_cnt_next;
                end
            end

            r_out_valid <= r_s1_valid && r_s1_last;
        end
    end

    assign in_ready  = w_en;
    assign out_valid = r_out_valid;
    assign out_acc   = r_out_acc;
    assign out_ovf   = r_out_ovf;
    assign out_cnt   = r_out_cnt;

endmodule

// File: tb/tb_mac_acc_pipe.sv
// Scoreboard bench for mac_acc_pipe: wrap and saturate instances share one stimulus stream,
// a vector-level reference model predicts each result, a monitor pops and compares.
module tb_mac_acc_pipe;

    localparam int A_W   = 4;
    localparam int B_W   = 4;
    localparam int ACC_W = 12;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic [ACC_W-1:0] acc;
        logic             ovf;
        logic [CNT_W-1:0] cnt;
    } res_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [A_W-1:0]   in_a;
    logic [B_W-1:0]   in_b;
    logic             in_last;
    logic             out_ready;

    logic             in_ready0, in_ready1;
    logic             out_valid0, out_valid1;
    logic [ACC_W-1:0] out_acc0, out_acc1;
    logic             out_ovf0, out_ovf1;
    logic [CNT_W-1:0] out_cnt0, out_cnt1;

    mac_acc_pipe #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_acc(out_acc0), .out_ovf(out_ovf0), .out_cnt(out_cnt0)
    );

    mac_acc_pipe #(.A_W(A_W), .B_W(B_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_acc(out_acc1), .out_ovf(out_ovf1), .out_cnt(out_cnt1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_checks = 0;
    int   n_errors = 0;
    res_t q_wrap[$];
    res_t q_sat[$];
    int   pop_cyc[$];
    res_t last_wrap, prev_wrap, last_sat;
    int   n_pushed = 0;
    int   acc_edge;
    int   rdy_mode = 0;  // 0: always ready, 1: random, 2: never ready

    // Reference model: whole-vector arithmetic on an unbounded sum.
    longint m_sum = 0;
    int     m_n   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_accept(input logic [A_W-1:0] a, input logic [B_W-1:0] b, input logic last);
        longint lim;
        res_t    rw, rs;
        m_sum += longint'(a) * longint'(b);
        m_n++;
        if (last) begin
            lim    = longint'(1) << ACC_W;
            rw.acc = ACC_W'(m_sum % lim);
            rw.ovf = (m_sum >= lim);
            rw.cnt = CNT_W'((m_n > 255) ? 255 : m_n);
            rs.acc = (m_sum >= lim) ? ACC_W'(lim - 1) : ACC_W'(m_sum);
            rs.ovf = (m_sum >= lim);
            rs.cnt = rw.cnt;
            q_wrap.push_back(rw);
            q_sat.push_back(rs);
            n_pushed++;
            m_sum = 0;
            m_n   = 0;
        end
    endtask

    // Downstream sink
    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_ready = 1'b1;
                2:       out_ready = 1'b0;
                default: out_ready = ($urandom_range(0, 99) < 70);
            endcase
        end
    end

    // Monitor: a result transfers on the next edge whenever valid and ready are both high.
    initial begin
        res_t e0, e1;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid0 && out_ready) begin
                if (q_wrap.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_result: got acc %0d with no result outstanding", out_acc0);
                end else begin
                    e0 = q_wrap.pop_front();
                    e1 = q_sat.pop_front();
                    check("wrap_acc", out_acc0, e0.acc);
                    check("wrap_ovf", out_ovf0, e0.ovf);
                    check("wrap_cnt", out_cnt0, e0.cnt);
                    check("sat_valid", out_valid1, 1);
                    check("sat_acc", out_acc1, e1.acc);
                    check("sat_ovf", out_ovf1, e1.ovf);
                    check("sat_cnt", out_cnt1, e1.cnt);
                    pop_cyc.push_back(cyc);
                    prev_wrap = last_wrap;
                    last_wrap = {out_acc0, out_ovf0, out_cnt0};
                    last_sat  = {out_acc1, out_ovf1, out_cnt1};
                end
            end
        end
    end

    task automatic send(input logic [A_W-1:0] a, input logic [B_W-1:0] b, input logic last);
        int guard = 0;
        bit done  = 0;
        while (!done) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = a;
            in_b     = b;
            in_last  = last;
            #1;
            if (in_ready0) begin
                done     = 1;
                acc_edge = cyc + 1;
                model_accept(a, b, last);
            end else if (++guard > 200) begin
                done = 1;
                n_errors++;
                $display("FAIL accept_timeout: in_ready low for %0d cycles, required 1 within 200", guard);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_a     = A_W'($urandom_range(0, 15));
            in_b     = B_W'($urandom_range(0, 15));
            in_last  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic drain();
        int g = 0;
        while ((q_wrap.size() > 0) && (g < 500)) begin
            @(negedge clk);
            in_valid = 1'b0;
            g++;
        end
        idle(2);
        check("queue_drained", q_wrap.size(), 0);
    endtask

    initial begin
        int n_before;
        int np;
        int len;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_last  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid0, 0);
        check("rst_out_acc", out_acc0, 0);
        check("rst_out_ovf", out_ovf0, 0);
        check("rst_out_cnt", out_cnt0, 0);
        check("rst_in_ready", in_ready0, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready0, 1);

        // Basic vector and latency
        send(3, 5, 0);
        send(15, 15, 0);
        send(2, 7, 1);
        np = acc_edge;
        drain();
        check("t1_acc", last_wrap.acc, 254);
        check("t1_cnt", last_wrap.cnt, 3);
        check("t1_ovf", last_wrap.ovf, 0);
        check("t1_latency", pop_cyc[pop_cyc.size()-1] - np, 1);

        // Overflow: wrap vs clamp
        repeat (18) send(15, 15, 0);
        send(15, 15, 1);
        drain();
        check("t2_wrap_acc", last_wrap.acc, 179);
        check("t2_wrap_ovf", last_wrap.ovf, 1);
        check("t2_wrap_cnt", last_wrap.cnt, 19);
        check("t2_sat_acc", last_sat.acc, 4095);
        check("t2_sat_ovf", last_sat.ovf, 1);

        // Output hold with back-pressure
        rdy_mode = 2;
        send(15, 15, 1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = 1;
            in_b     = 2;
            in_last  = 1'b1;
            #1;
            check("hold_out_valid", out_valid0, 1);
            check("hold_out_acc", out_acc0, 225);
            check("hold_in_ready", in_ready0, 0);
        end
        rdy_mode = 0;
        send(1, 2, 1);
        drain();
        check("t3_next_acc", last_wrap.acc, 2);
        check("t3_next_cnt", last_wrap.cnt, 1);

        // Back-to-back vectors
        send(1, 1, 0);
        send(2, 2, 1);
        send(3, 3, 1);
        drain();
        np = pop_cyc.size();
        check("t4_consecutive", pop_cyc[np-1] - pop_cyc[np-2], 1);
        check("t4_first_acc", prev_wrap.acc, 5);
        check("t4_first_cnt", prev_wrap.cnt, 2);
        check("t4_second_acc", last_wrap.acc, 9);
        check("t4_second_cnt", last_wrap.cnt, 1);

        // Reset mid-vector
        send(1, 2, 0);
        send(3, 4, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        m_sum = 0;
        m_n   = 0;
        #1;
        check("t5_rst_out_valid", out_valid0, 0);
        check("t5_rst_in_ready", in_ready0, 1);
        n_before = pop_cyc.size();
        send(4, 4, 1);
        drain();
        check("t5_one_result", pop_cyc.size() - n_before, 1);
        check("t5_acc", last_wrap.acc, 16);
        check("t5_cnt", last_wrap.cnt, 1);

        // Long vector: element counter saturates
        for (int i = 0; i < 300; i++) begin
            send(A_W'($urandom_range(0, 15)), B_W'($urandom_range(0, 15)), i == 299);
        end
        drain();
        check("t6_cnt_sat", last_wrap.cnt, 255);

        // Random traffic with input gaps and output back-pressure
        rdy_mode = 1;
        n_before = pop_cyc.size();
        np       = n_pushed;
        for (int v = 0; v < 1000; v++) begin
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 30) : $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                if ($urandom_range(0, 1) == 0)
                    send(15, A_W'($urandom_range(8, 15)), i == len - 1);
                else
                    send(A_W'($urandom_range(0, 15)), B_W'($urandom_range(0, 15)), i == len - 1);
            end
        end
        rdy_mode = 0;
        drain();
        check("t7_result_count", pop_cyc.size() - n_before, n_pushed - np);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
